// File: rtl/vending_if.sv
// Command/result bundle for the vending controller.
// The master side issues mode/productCode/productCount/amount with a
// cmdValid/cmdReady handshake; the slave side returns the completion pulse,
// error status, dispense strobe, money registers and display values.
interface vending_if #(
    parameter int CODE_W  = 3,
    parameter int COUNT_W = 4,
    parameter int MONEY_W = 8
);
    logic [2:0]         mode;
    logic               cmdValid;
    logic               cmdReady;
    logic [CODE_W-1:0]  productCode;
    logic [COUNT_W-1:0] productCount;
    logic [MONEY_W-1:0] amount;
    logic               done;
    logic               isError;
    logic [2:0]         errCode;
    logic               dispenseValid;
    logic [CODE_W-1:0]  dispenseCode;
    logic [MONEY_W-1:0] refundAmount;
    logic [MONEY_W-1:0] customerMoney;
    logic [MONEY_W-1:0] machineMoney;
    logic [2:0]         dispMode;
    logic [MONEY_W-1:0] dispValue;

    modport master (
        output mode, cmdValid, productCode, productCount, amount,
        input  cmdReady, done, isError, errCode, dispenseValid, dispenseCode,
               refundAmount, customerMoney, machineMoney, dispMode, dispValue
    );

    modport slave (
        input  mode, cmdValid, productCode, productCount, amount,
        output cmdReady, done, isError, errCode, dispenseValid, dispenseCode,
               refundAmount, customerMoney, machineMoney, dispMode, dispValue
    );
endinterface

// File: rtl/vending_controller.sv
// Vending-machine top controller: accepts one command at a time through the
// handshake, runs it through IDLE -> EXEC -> (BUY_ACC)* -> FINISH, and owns
// the per-slot stock/price tables plus customer and machine credit.
// All results (done, errors, money, display) become visible together on the
// cycle after FINISH, so a sampler of done sees a consistent picture.
// Optional feature: define VEND_AUDIT_EN to add saturating auditSales and
// auditRevenue counters fed by successful buys.
module vending_controller #(
    parameter int N_PRODUCTS    = 8,
    parameter int CODE_W        = 3,
    parameter int COUNT_W       = 4,
    parameter int MONEY_W       = 8,
    parameter int DEFAULT_PRICE = 1
) (
    input  logic      mainClock,
    input  logic      mainReset,
    vending_if.slave  bus
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0] auditSales,
    output logic [15:0] auditRevenue
`endif
);
    // Accumulator is wide enough for count * max price, so it never wraps.
    localparam int ACC_W = MONEY_W + COUNT_W;

    localparam logic [2:0] M_BUY      = 3'd0;
    localparam logic [2:0] M_RESTOCK  = 3'd1;
    localparam logic [2:0] M_INSERT   = 3'd2;
    localparam logic [2:0] M_REFUND   = 3'd3;
    localparam logic [2:0] M_SETPRICE = 3'd4;
    localparam logic [2:0] M_SHOWC    = 3'd5;
    localparam logic [2:0] M_SHOWM    = 3'd6;
    localparam logic [2:0] M_COLLECT  = 3'd7;

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_CODE  = 3'd1;
    localparam logic [2:0] E_STOCK = 3'd2;
    localparam logic [2:0] E_FUNDS = 3'd3;
    localparam logic [2:0] E_OVF   = 3'd4;
    localparam logic [2:0] E_ZERO  = 3'd5;

    localparam logic [MONEY_W-1:0] LP_DEF_PRICE = MONEY_W'(DEFAULT_PRICE);
    localparam logic [CODE_W:0]    LP_NPROD     = (CODE_W+1)'(N_PRODUCTS);
    localparam logic [ACC_W:0]     LP_MONEY_MAX = (ACC_W+1)'((1 << MONEY_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUY_ACC, S_FINISH} state_t;

    state_t             r_state, w_state_next;
    logic [2:0]         r_mode;
    logic [CODE_W-1:0]  r_code;
    logic [COUNT_W-1:0] r_count, r_cnt;
    logic [MONEY_W-1:0] r_amount, r_price;
    logic [2:0]         r_err;
    logic [ACC_W-1:0]   r_acc;

    logic               r_done, r_is_error, r_disp_valid;
    logic [2:0]         r_err_code, r_disp_mode;
    logic [CODE_W-1:0]  r_disp_code;
    logic [MONEY_W-1:0] r_refund, r_cust, r_mach, r_disp_value;

    logic [COUNT_W-1:0] w_stock [N_PRODUCTS];
    logic [MONEY_W-1:0] w_price [N_PRODUCTS];
    logic [COUNT_W-1:0] w_stock_sel;
    logic [MONEY_W-1:0] w_price_sel;
    logic               w_accept, w_code_ok, w_commit;
    logic [2:0]         w_exec_err, w_fin_err;
    logic [ACC_W:0]     w_mach_sum;
    logic [MONEY_W:0]   w_cust_sum;
    logic [COUNT_W:0]   w_stock_sum;

    assign w_accept    = bus.cmdValid && (r_state == S_IDLE);
    assign w_code_ok   = ({1'b0, r_code} < LP_NPROD);
    assign w_mach_sum  = (ACC_W+1)'(r_mach) + (ACC_W+1)'(r_acc);
    assign w_cust_sum  = {1'b0, r_cust} + {1'b0, r_amount};
    assign w_stock_sum = {1'b0, w_stock_sel} + {1'b0, r_count};
    assign w_commit    = (r_state == S_FINISH) && (w_fin_err == E_OK);

    // Select the latched slot's stock and price; out-of-range codes read zero.
    always_comb begin
        w_stock_sel = '0;
        w_price_sel = '0;
        for (int i = 0; i < N_PRODUCTS; i++) begin
            if (r_code == CODE_W'(i)) begin
                w_stock_sel = w_stock[i];
                w_price_sel = w_price[i];
            end
        end
    end

    // Per-slot stock and price registers, updated only on a committed command.
    for (genvar gi = 0; gi < N_PRODUCTS; gi++) begin : g_slot
        localparam logic [CODE_W-1:0] LP_IDX = CODE_W'(gi);
        logic [COUNT_W-1:0] r_stock;
        logic [MONEY_W-1:0] r_price_ent;

        // Slot update on buy, restock or set-price commit.
        always_ff @(posedge mainClock) begin
            if (mainReset) begin
                r_stock     <= '0;
                r_price_ent <= LP_DEF_PRICE;
            end else if (w_commit && (r_code == LP_IDX)) begin
                case (r_mode)
                    M_BUY:      r_stock     <= r_stock - r_count;
                    M_RESTOCK:  r_stock     <= w_stock_sum[COUNT_W-1:0];
                    M_SETPRICE: r_price_ent <= r_amount;
                    default: ;
                endcase
            end
        end

        assign w_stock[gi] = r_stock;
        assign w_price[gi] = r_price_ent;
    end

    // Early checks done in EXEC: slot range, zero count, then stock availability.
    always_comb begin
        w_exec_err = E_OK;
        if ((r_mode == M_BUY || r_mode == M_RESTOCK || r_mode == M_SETPRICE) && !w_code_ok)
            w_exec_err = E_CODE;
        else if ((r_mode == M_BUY || r_mode == M_RESTOCK) && (r_count == '0))
            w_exec_err = E_ZERO;
        else if ((r_mode == M_BUY) && (w_stock_sel < r_count))
            w_exec_err = E_STOCK;
    end

    // Final error decided in FINISH: an EXEC error wins, then funds and overflow checks.
    always_comb begin
        w_fin_err = r_err;
        if (r_err == E_OK) begin
            case (r_mode)
                M_BUY: begin
                    if (r_acc > ACC_W'(r_cust))
                        w_fin_err = E_FUNDS;
                    else if (w_mach_sum > LP_MONEY_MAX)
                        w_fin_err = E_OVF;
                end
                M_RESTOCK: if (w_stock_sum[COUNT_W]) w_fin_err = E_OVF;
                M_INSERT:  if (w_cust_sum[MONEY_W])  w_fin_err = E_OVF;
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge mainClock) begin
        if (mainReset) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    // FSM next-state: buys that pass EXEC spend count cycles accumulating.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_EXEC;
            S_EXEC:    w_state_next = (r_mode == M_BUY && w_exec_err == E_OK) ? S_BUY_ACC : S_FINISH;
            S_BUY_ACC: if (r_cnt == COUNT_W'(1)) w_state_next = S_FINISH;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch on accept, prepare in EXEC, accumulate, commit in FINISH.
    always_ff @(posedge mainClock) begin
        if (mainReset) begin
            r_mode       <= '0;
            r_code       <= '0;
            r_count      <= '0;
            r_amount     <= '0;
            r_err        <= E_OK;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_price      <= '0;
            r_done       <= 1'b0;
            r_is_error   <= 1'b0;
            r_err_code   <= E_OK;
            r_disp_valid <= 1'b0;
            r_disp_code  <= '0;
            r_refund     <= '0;
            r_cust       <= '0;
            r_mach       <= '0;
            r_disp_mode  <= '0;
            r_disp_value <= '0;
        end else begin
            r_done       <= 1'b0;
            r_disp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode      <= bus.mode;
                        r_code      <= bus.productCode;
                        r_count     <= bus.productCount;
                        r_amount    <= bus.amount;
                        r_disp_mode <= bus.mode;
                        r_is_error  <= 1'b0;
                        r_err_code  <= E_OK;
                    end
                end
                S_EXEC: begin
                    r_err   <= w_exec_err;
                    r_acc   <= '0;
                    r_cnt   <= r_count;
                    r_price <= w_price_sel;
                end
                S_BUY_ACC: begin
                    r_acc <= r_acc + ACC_W'(r_price);
                    r_cnt <= r_cnt - COUNT_W'(1);
                end
                S_FINISH: begin
                    r_done     <= 1'b1;
                    r_is_error <= (w_fin_err != E_OK);
                    r_err_code <= w_fin_err;
                    if (w_fin_err == E_OK) begin
                        case (r_mode)
                            M_BUY: begin
                                r_cust       <= r_cust - r_acc[MONEY_W-1:0];
                                r_mach       <= w_mach_sum[MONEY_W-1:0];
                                r_disp_valid <= 1'b1;
                                r_disp_code  <= r_code;
                            end
                            M_INSERT: r_cust <= w_cust_sum[MONEY_W-1:0];
                            M_REFUND: begin
                                r_refund <= r_cust;
                                r_cust   <= '0;
                            end
                            M_SHOWC: r_disp_value <= r_cust;
                            M_SHOWM: r_disp_value <= r_mach;
                            M_COLLECT: begin
                                r_disp_value <= r_mach;
                                r_mach       <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VEND_AUDIT_EN
    logic [15:0] r_audit_sales, r_audit_rev;
    logic [16:0] w_sales_sum, w_rev_sum;

    assign w_sales_sum = 17'(r_audit_sales) + 17'(r_count);
    assign w_rev_sum   = 17'(r_audit_rev) + 17'(r_acc);

    // Saturating sales/revenue totals for successful buys; cleared only by reset.
    always_ff @(posedge mainClock) begin
        if (mainReset) begin
            r_audit_sales <= '0;
            r_audit_rev   <= '0;
        end else if (w_commit && (r_mode == M_BUY)) begin
            r_audit_sales <= w_sales_sum[16] ? 16'hFFFF : w_sales_sum[15:0];
            r_audit_rev   <= w_rev_sum[16]   ? 16'hFFFF : w_rev_sum[15:0];
        end
    end

    assign auditSales   = r_audit_sales;
    assign auditRevenue = r_audit_rev;
`endif

    assign bus.cmdReady      = (r_state == S_IDLE);
    assign bus.done          = r_done;
    assign bus.isError       = r_is_error;
    assign bus.errCode       = r_err_code;
    assign bus.dispenseValid = r_disp_valid;
    assign bus.dispenseCode  = r_disp_code;
    assign bus.refundAmount  = r_refund;
    assign bus.customerMoney = r_cust;
    assign bus.machineMoney  = r_mach;
    assign bus.dispMode      = r_disp_mode;
    assign bus.dispValue     = r_disp_value;
endmodule

// File: tb/tb_vending_controller.sv
// Testbench for vending_controller: directed scenarios followed by random
// commands. A reference model computes the expected result of each accepted
// command and queues it; a monitor pops and compares whenever done pulses.
module tb_vending_controller;
    localparam int NP   = 6;
    localparam int CW   = 3;
    localparam int KW   = 4;
    localparam int MW   = 8;
    localparam int MMAX = 255;
    localparam int KMAX = 15;

    logic mainClock = 1'b0;
    logic mainReset = 1'b1;
    int   cycle = 0;

    vending_if #(.CODE_W(CW), .COUNT_W(KW), .MONEY_W(MW)) bus();

`ifdef VEND_AUDIT_EN
    logic [15:0] audit_sales, audit_rev;
`endif

    vending_controller #(
        .N_PRODUCTS(NP), .CODE_W(CW), .COUNT_W(KW), .MONEY_W(MW), .DEFAULT_PRICE(1)
    ) dut (
        .mainClock(mainClock),
        .mainReset(mainReset),
        .bus(bus)
`ifdef VEND_AUDIT_EN
        ,
        .auditSales(audit_sales),
        .auditRevenue(audit_rev)
`endif
    );

    always #5 mainClock = ~mainClock;
    always @(posedge mainClock) cycle <= cycle + 1;

    typedef struct {
        int acc_cyc; int lat; int err; int cust; int mach; int dval;
        int refund; int dv; int dcode; int dmode;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    int m_stock[8];
    int m_price[8];
    int m_cust, m_mach, m_dval, m_refund, m_dcode, m_sales, m_rev;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_stock[i] = 0;
            m_price[i] = 1;
        end
        m_cust = 0; m_mach = 0; m_dval = 0; m_refund = 0; m_dcode = 0;
        m_sales = 0; m_rev = 0;
    endtask

    // Apply one command's rules to the model and queue its expected result.
    task automatic model_cmd(input int md, input int code, input int cnt, input int amt, input int acc_cyc);
        exp_t e;
        int cost;
        bit legal;
        legal = (code < NP);
        e.err = 0; e.lat = 2; e.dv = 0;
        case (md)
            0: begin
                if (!legal) e.err = 1;
                else if (cnt == 0) e.err = 5;
                else if (m_stock[code] < cnt) e.err = 2;
                else begin
                    e.lat = 2 + cnt;
                    cost = m_price[code] * cnt;
                    if (cost > m_cust) e.err = 3;
                    else if (m_mach + cost > MMAX) e.err = 4;
                    else begin
                        m_cust -= cost;
                        m_mach += cost;
                        m_stock[code] -= cnt;
                        e.dv = 1;
                        m_dcode = code;
                        m_sales = (m_sales + cnt > 65535) ? 65535 : m_sales + cnt;
                        m_rev   = (m_rev + cost > 65535) ? 65535 : m_rev + cost;
                    end
                end
            end
            1: begin
                if (!legal) e.err = 1;
                else if (cnt == 0) e.err = 5;
                else if (m_stock[code] + cnt > KMAX) e.err = 4;
                else m_stock[code] += cnt;
            end
            2: begin
                if (m_cust + amt > MMAX) e.err = 4;
                else m_cust += amt;
            end
            3: begin
                m_refund = m_cust;
                m_cust = 0;
            end
            4: begin
                if (!legal) e.err = 1;
                else m_price[code] = amt;
            end
            5: m_dval = m_cust;
            6: m_dval = m_mach;
            default: begin
                m_dval = m_mach;
                m_mach = 0;
            end
        endcase
        e.acc_cyc = acc_cyc;
        e.cust = m_cust; e.mach = m_mach; e.dval = m_dval; e.refund = m_refund;
        e.dcode = m_dcode; e.dmode = md;
        exp_q.push_back(e);
    endtask

    // Issue one command, inject ignored traffic while busy, wait for done.
    task automatic issue(input int md, input int code, input int cnt, input int amt);
        int w;
        w = 0;
        while (!bus.cmdReady && w < 50) begin
            @(negedge mainClock);
            w++;
        end
        if (!bus.cmdReady) begin
            chk("ready_timeout", int'(bus.cmdReady), 1);
            return;
        end
        bus.mode = 3'(md);
        bus.productCode = 3'(code);
        bus.productCount = 4'(cnt);
        bus.amount = 8'(amt);
        bus.cmdValid = 1'b1;
        @(negedge mainClock);
        model_cmd(md, code, cnt, amt, cycle);
        bus.mode = 3'($urandom);
        bus.productCode = 3'($urandom);
        bus.productCount = 4'($urandom);
        bus.amount = 8'($urandom);
        @(negedge mainClock);
        bus.cmdValid = 1'b0;
        w = 0;
        while (!bus.done && w < 40) begin
            @(negedge mainClock);
            w++;
        end
        if (!bus.done) chk("done_timeout", int'(bus.done), 1);
    endtask

    // Monitor: compare every completion against the oldest queued expectation.
    always @(negedge mainClock) begin
        if (!mainReset) begin
            if (bus.dispenseValid && !bus.done)
                chk("dispense_without_done", int'(bus.dispenseValid), 0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", cycle - mon_e.acc_cyc, mon_e.lat);
                    chk("errCode", int'(bus.errCode), mon_e.err);
                    chk("isError", int'(bus.isError), (mon_e.err != 0) ? 1 : 0);
                    chk("customerMoney", int'(bus.customerMoney), mon_e.cust);
                    chk("machineMoney", int'(bus.machineMoney), mon_e.mach);
                    chk("dispValue", int'(bus.dispValue), mon_e.dval);
                    chk("refundAmount", int'(bus.refundAmount), mon_e.refund);
                    chk("dispenseValid", int'(bus.dispenseValid), mon_e.dv);
                    chk("dispenseCode", int'(bus.dispenseCode), mon_e.dcode);
                    chk("dispMode", int'(bus.dispMode), mon_e.dmode);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmdReady"}, int'(bus.cmdReady), 1);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_isError"}, int'(bus.isError), 0);
        chk({tag, "_errCode"}, int'(bus.errCode), 0);
        chk({tag, "_cust"}, int'(bus.customerMoney), 0);
        chk({tag, "_mach"}, int'(bus.machineMoney), 0);
        chk({tag, "_dispValue"}, int'(bus.dispValue), 0);
        chk({tag, "_refund"}, int'(bus.refundAmount), 0);
        chk({tag, "_dispMode"}, int'(bus.dispMode), 0);
        chk({tag, "_dispCode"}, int'(bus.dispenseCode), 0);
        chk({tag, "_dispValid"}, int'(bus.dispenseValid), 0);
`ifdef VEND_AUDIT_EN
        chk({tag, "_auditSales"}, int'(audit_sales), 0);
        chk({tag, "_auditRevenue"}, int'(audit_rev), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int md, code, cnt, amt;
        bus.cmdValid = 1'b0;
        bus.mode = '0; bus.productCode = '0; bus.productCount = '0; bus.amount = '0;
        model_reset();
        repeat (3) @(negedge mainClock);
        mainReset = 1'b0;
        check_reset_state("reset");

        // Directed scenarios.
        issue(2, 0, 0, 10);
        chk("insert10_cust", int'(bus.customerMoney), 10);
        issue(4, 2, 0, 3);
        issue(1, 2, 4, 0);
        issue(0, 2, 3, 0);
        chk("buy_cust", int'(bus.customerMoney), 1);
        chk("buy_mach", int'(bus.machineMoney), 9);
        chk("buy_dispense_code", int'(bus.dispenseCode), 2);
        issue(0, 2, 2, 0);
        chk("nostock_err", int'(bus.errCode), 2);
        issue(0, 2, 1, 0);
        chk("nofunds_err", int'(bus.errCode), 3);
        issue(2, 0, 0, 9);
        issue(2, 0, 0, 250);
        chk("insert_ovf_err", int'(bus.errCode), 4);
        chk("insert_ovf_cust", int'(bus.customerMoney), 10);
        issue(0, 7, 1, 0);
        chk("badcode_err", int'(bus.errCode), 1);
        issue(1, 3, 0, 0);
        chk("zerocount_err", int'(bus.errCode), 5);
        issue(3, 0, 0, 0);
        chk("refund_amount", int'(bus.refundAmount), 10);
        issue(5, 0, 0, 0);
        issue(7, 0, 0, 0);
        chk("collect_dispValue", int'(bus.dispValue), 9);
        chk("collect_mach", int'(bus.machineMoney), 0);
`ifdef VEND_AUDIT_EN
        chk("auditSales_directed", int'(audit_sales), 3);
        chk("auditRevenue_directed", int'(audit_rev), 9);
`endif

        // Reset in the middle of a buy's accumulation phase.
        issue(2, 0, 0, 50);
        issue(1, 0, 5, 0);
        @(negedge mainClock);
        bus.mode = 3'd0; bus.productCode = 3'd0; bus.productCount = 4'd5; bus.amount = 8'd0;
        bus.cmdValid = 1'b1;
        @(negedge mainClock);
        bus.cmdValid = 1'b0;
        @(negedge mainClock);
        mainReset = 1'b1;
        @(negedge mainClock);
        mainReset = 1'b0;
        model_reset();
        check_reset_state("abort");
        for (int i = 0; i < 6; i++) begin
            @(negedge mainClock);
            chk("abort_no_dispense", int'(bus.dispenseValid | bus.done), 0);
        end
        issue(0, 0, 1, 0);
        chk("abort_stock_cleared", int'(bus.errCode), 2);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            md   = int'($urandom_range(0, 7));
            code = int'($urandom_range(0, 7));
            cnt  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            if (md == 2)
                amt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 80));
            else
                amt = int'($urandom_range(0, 12));
            issue(md, code, cnt, amt);
        end

        repeat (4) @(negedge mainClock);
        chk("queue_drained", exp_q.size(), 0);
`ifdef VEND_AUDIT_EN
        chk("auditSales_final", int'(audit_sales), m_sales);
        chk("auditRevenue_final", int'(audit_rev), m_rev);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
